// File: rtl/keypad_scanner.sv
// keypad_scanner: 3x3 matrix keypad scanner with debounce and one-clock press pulses per cell.
// Optional auto-repeat while a key is held is enabled by defining KEYPAD_AUTOREPEAT_EN.
module keypad_scanner #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int SETTLE_CYCLES   = 2,
    parameter int REPEAT_CYCLES   = 200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scan_en,
    input  logic [2:0] col_n,
    output logic [2:0] row_n,
    output logic       a_button,
    output logic       b_button,
    output logic       c_button,
    output logic       d_button,
    output logic       e_button,
    output logic       f_button,
    output logic       g_button,
    output logic       h_button,
    output logic       i_button,
    output logic       key_valid,
    output logic [3:0] key_code
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SETTLE   = 3'd1,
        SAMPLE   = 3'd2,
        DEBOUNCE = 3'd3,
        PRESS    = 3'd4,
        HOLD     = 3'd5,
        RELEASE  = 3'd6
    } state_t;

    localparam logic [7:0] DEB_LAST = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0] SET_LAST = 8'(SETTLE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 255 || SETTLE_CYCLES < 1 ||
        SETTLE_CYCLES > 15 || REPEAT_CYCLES < 2 || REPEAT_CYCLES > 65535) begin : g_param_check
        $error("keypad_scanner: parameter out of range");
    end

    function automatic logic [1:0] next_row(input logic [1:0] r);
        logic [1:0] n;
        case (r)
            2'd0:    n = 2'd1;
            2'd1:    n = 2'd2;
            default: n = 2'd0;
        endcase
        return n;
    endfunction

    function automatic logic [2:0] one_low(input logic [1:0] idx);
        logic [2:0] v;
        case (idx)
            2'd0:    v = 3'b110;
            2'd1:    v = 3'b101;
            default: v = 3'b011;
        endcase
        return v;
    endfunction

    function automatic logic [1:0] low_col(input logic [2:0] cols);
        logic [1:0] idx;
        case (cols)
            3'b110:  idx = 2'd0;
            3'b101:  idx = 2'd1;
            default: idx = 2'd2;
        endcase
        return idx;
    endfunction

    function automatic logic [3:0] cell_code(input logic [1:0] r, input logic [1:0] c);
        return ({2'b00, r} << 1) + {2'b00, r} + {2'b00, c};
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    state_t      state_q, state_d;
    logic [1:0]  row_q, row_d;
    logic [1:0]  col_idx_q, col_idx_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [2:0]  col_s1_q, col_s2_q;
    logic [2:0]  row_n_q, row_n_d;
    logic [8:0]  btn_q, btn_d;
    logic        key_valid_q, key_valid_d;
    logic [3:0]  key_code_q, key_code_d;
    logic        col_hi_s;
`ifdef KEYPAD_AUTOREPEAT_EN
    localparam logic [15:0] RPT_LAST = 16'(REPEAT_CYCLES - 2);
    logic [15:0] rpt_q, rpt_d;
`endif

    assign col_hi_s = |(col_s2_q & ~one_low(col_idx_q));

    // Next-state, counter and registered-output computation for the scan FSM.
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_idx_d   = col_idx_q;
        cnt_d       = cnt_q;
        key_code_d  = key_code_q;
        btn_d       = 9'd0;
        key_valid_d = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
        rpt_d       = rpt_q;
`endif
        if (!scan_en) begin
            state_d = IDLE;
            row_d   = 2'd0;
            cnt_d   = 8'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = SETTLE;
                    row_d   = 2'd0;
                    cnt_d   = 8'd0;
                end
                SETTLE: begin
                    if (cnt_q >= SET_LAST) begin
                        state_d = SAMPLE;
                        cnt_d   = 8'd0;
                    end else begin
                        cnt_d = sat_inc8(cnt_q);
                    end
                end
                SAMPLE: begin
                    if (col_s2_q == 3'b110 || col_s2_q == 3'b101 || col_s2_q == 3'b011) begin
                        col_idx_d = low_col(col_s2_q);
                        state_d   = DEBOUNCE;
                    end else begin
                        row_d   = next_row(row_q);
                        state_d = SETTLE;
                    end
                    cnt_d = 8'd0;
                end
                DEBOUNCE: begin
                    if (col_s2_q == one_low(col_idx_q)) begin
                        if (cnt_q >= DEB_LAST) begin
                            state_d = PRESS;
                            cnt_d   = 8'd0;
                        end else begin
                            cnt_d = sat_inc8(cnt_q);
                        end
                    end else begin
                        row_d   = next_row(row_q);
                        state_d = SETTLE;
                        cnt_d   = 8'd0;
                    end
                end
                PRESS: begin
                    state_d = HOLD;
`ifdef KEYPAD_AUTOREPEAT_EN
                    rpt_d   = 16'd0;
`endif
                end
                HOLD: begin
                    if (col_hi_s) begin
                        state_d = RELEASE;
                        cnt_d   = 8'd0;
`ifdef KEYPAD_AUTOREPEAT_EN
                        rpt_d   = 16'd0;
                    end else if (rpt_q >= RPT_LAST) begin
                        // PRESS counts as one clock of the repeat interval
                        state_d = PRESS;
                    end else begin
                        rpt_d = (rpt_q == 16'hFFFF) ? rpt_q : rpt_q + 16'd1;
`else
                    end else begin
                        state_d = HOLD;
`endif
                    end
                end
                RELEASE: begin
                    if (col_s2_q == 3'b111) begin
                        if (cnt_q >= DEB_LAST) begin
                            row_d   = next_row(row_q);
                            state_d = SETTLE;
                            cnt_d   = 8'd0;
                        end else begin
                            cnt_d = sat_inc8(cnt_q);
                        end
                    end else begin
                        cnt_d   = 8'd0;
                        state_d = col_hi_s ? RELEASE : HOLD;
                    end
                end
                default: begin
                    state_d = IDLE;
                    row_d   = 2'd0;
                    cnt_d   = 8'd0;
                end
            endcase
        end
        row_n_d = (state_d == IDLE) ? 3'b111 : one_low(row_d);
        // Outputs are registered so the pulse lines up with the PRESS state cycle
        if (state_d == PRESS) begin
            key_code_d  = cell_code(row_d, col_idx_d);
            btn_d       = 9'b000000001 << key_code_d;
            key_valid_d = 1'b1;
        end else begin
            btn_d       = 9'd0;
            key_valid_d = 1'b0;
        end
    end

    // State, synchronizer and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            row_q       <= 2'd0;
            col_idx_q   <= 2'd0;
            cnt_q       <= 8'd0;
            col_s1_q    <= 3'b111;
            col_s2_q    <= 3'b111;
            row_n_q     <= 3'b111;
            btn_q       <= 9'd0;
            key_valid_q <= 1'b0;
            key_code_q  <= 4'hF;
`ifdef KEYPAD_AUTOREPEAT_EN
            rpt_q       <= 16'd0;
`endif
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_idx_q   <= col_idx_d;
            cnt_q       <= cnt_d;
            col_s1_q    <= col_n;
            col_s2_q    <= col_s1_q;
            row_n_q     <= row_n_d;
            btn_q       <= btn_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
`ifdef KEYPAD_AUTOREPEAT_EN
            rpt_q       <= rpt_d;
`endif
        end
    end

    assign row_n     = row_n_q;
    assign a_button  = btn_q[0];
    assign b_button  = btn_q[1];
    assign c_button  = btn_q[2];
    assign d_button  = btn_q[3];
    assign e_button  = btn_q[4];
    assign f_button  = btn_q[5];
    assign g_button  = btn_q[6];
    assign h_button  = btn_q[7];
    assign i_button  = btn_q[8];
    assign key_valid = key_valid_q;
    assign key_code  = key_code_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad model drives col_n from row_n; a scoreboard queue of
// expected pulses is filled when keys are pressed and drained as the DUT pulses.
module tb_keypad_scanner;
    localparam int DEB = 16;
    localparam int LAT = 2 + DEB + 1;
`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int EXP_RPT = 3;
`else
    localparam int EXP_RPT = 0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       scan_en;
    logic [2:0] col_n;
    logic [2:0] row_n;
    logic       a_button, b_button, c_button, d_button, e_button;
    logic       f_button, g_button, h_button, i_button;
    logic       key_valid;
    logic [3:0] key_code;
    logic [8:0] keys;
    logic [8:0] btn_vec;

    keypad_scanner #(.DEBOUNCE_CYCLES(DEB), .SETTLE_CYCLES(2), .REPEAT_CYCLES(50)) dut (
        .clk(clk), .reset(reset), .scan_en(scan_en), .col_n(col_n), .row_n(row_n),
        .a_button(a_button), .b_button(b_button), .c_button(c_button),
        .d_button(d_button), .e_button(e_button), .f_button(f_button),
        .g_button(g_button), .h_button(h_button), .i_button(i_button),
        .key_valid(key_valid), .key_code(key_code)
    );

    always #5 clk = ~clk;

    assign btn_vec = {i_button, h_button, g_button, f_button, e_button,
                      d_button, c_button, b_button, a_button};

    // Passive keypad matrix: a pressed key pulls its column low while its row is driven.
    always_comb begin
        col_n = 3'b111;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                if (!row_n[r] && keys[r*3+c]) col_n[c] = 1'b0;
    end

    typedef struct { int key; logic [3:0] code; logic [8:0] btn; } vec_t;
    typedef struct { logic [3:0] code; logic [8:0] btn; } exp_t;

    vec_t tbl[9];
    exp_t exp_q[$];
    int   pulse_times[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   pulses = 0;
    int   last_pulse = 0;
    logic [2:0] prev_row = 3'b111;
    logic [2:0] row_seen = 3'b111;

    function automatic logic [2:0] row_pat(input int r);
        return (r == 0) ? 3'b110 : (r == 1) ? 3'b101 : 3'b011;
    endfunction

    function automatic logic [2:0] row_after(input logic [2:0] r);
        return (r == 3'b110) ? 3'b101 : (r == 3'b101) ? 3'b011 : 3'b110;
    endfunction

    task automatic chk(input bit ok, input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        prev_row = row_seen;
        row_seen = row_n;
        chk(key_valid === |btn_vec, "valid_vs_cells", {15'd0, key_valid}, {15'd0, |btn_vec});
        chk($countones(btn_vec) <= 1, "cells_onehot", {7'd0, btn_vec}, 16'd0);
        chk(row_n inside {3'b111, 3'b110, 3'b101, 3'b011}, "row_legal", {13'd0, row_n}, 16'd0);
        if (key_valid === 1'b1) begin
            pulses++;
            last_pulse = cyc;
            pulse_times.push_back(cyc);
            chk(exp_q.size() != 0, "unexpected_pulse", {7'd0, btn_vec}, 16'd0);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk(btn_vec === e.btn, "cell_pulse", {7'd0, btn_vec}, {7'd0, e.btn});
                chk(key_code === e.code, "pulse_key_code", {12'd0, key_code}, {12'd0, e.code});
            end
        end
    endtask

    task automatic wait_empty(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
        chk(exp_q.size() == 0, "pulse_timeout", 16'(exp_q.size()), 16'd0);
        exp_q.delete();
    endtask

    task automatic wait_row(input int r);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!(row_seen == row_pat(r) && prev_row != row_pat(r)) && n < 40);
        chk(row_seen == row_pat(r), "row_reached", {13'd0, row_seen}, {13'd0, row_pat(r)});
    endtask

    task automatic push_exp(input logic [3:0] code, input logic [8:0] btn);
        exp_t e;
        e.code = code;
        e.btn  = btn;
        exp_q.push_back(e);
    endtask

    initial begin
        int t0;
        int n0;
        int base;
        int n_chg;
        tbl[0] = '{4, 4'd4, 9'b000010000};
        tbl[1] = '{0, 4'd0, 9'b000000001};
        tbl[2] = '{1, 4'd1, 9'b000000010};
        tbl[3] = '{2, 4'd2, 9'b000000100};
        tbl[4] = '{3, 4'd3, 9'b000001000};
        tbl[5] = '{5, 4'd5, 9'b000100000};
        tbl[6] = '{6, 4'd6, 9'b001000000};
        tbl[7] = '{7, 4'd7, 9'b010000000};
        tbl[8] = '{8, 4'd8, 9'b100000000};

        reset   = 1'b0;
        scan_en = 1'b0;
        keys    = 9'd0;
        repeat (3) tick();
        chk(row_n == 3'b111, "reset_rows", {13'd0, row_n}, 16'h0007);
        chk(key_code == 4'hF, "reset_code", {12'd0, key_code}, 16'h000F);
        chk(btn_vec == 9'd0 && key_valid == 1'b0, "reset_cells", {7'd0, btn_vec}, 16'd0);
        reset = 1'b1;
        repeat (5) tick();
        chk(row_n == 3'b111, "idle_rows", {13'd0, row_n}, 16'h0007);
        scan_en = 1'b1;

        // Every key from its row's first driven cycle: exact latency and mapping
        for (int t = 0; t < 9; t++) begin
            wait_row(tbl[t].key / 3);
            keys = 9'b000000001 << tbl[t].key;
            t0 = cyc;
            push_exp(tbl[t].code, tbl[t].btn);
            wait_empty(LAT + 10);
            chk(last_pulse - t0 == LAT, "press_latency", 16'(last_pulse - t0), 16'(LAT));
            repeat (30) tick();
            keys = 9'd0;
            repeat (30) tick();
            chk(key_code == tbl[t].code, "code_after_release", {12'd0, key_code}, {12'd0, tbl[t].code});
        end

        // g bouncing every 3 clocks, then stable
        for (int k = 0; k < 10; k++) begin
            keys = ((k % 2) == 0) ? 9'b001000000 : 9'b000000000;
            repeat (3) tick();
        end
        keys = 9'b001000000;
        t0 = cyc;
        push_exp(4'd6, 9'b001000000);
        wait_empty(LAT + 40);
        chk(last_pulse - t0 >= LAT, "bounce_latency", 16'(last_pulse - t0), 16'(LAT));
        repeat (40) tick();
        keys = 9'd0;
        repeat (30) tick();

        // a and b together: no pulse, rows keep cycling
        keys = 9'b000000011;
        n_chg = 0;
        repeat (90) begin
            tick();
            if (row_seen != prev_row) begin
                chk(row_seen == row_after(prev_row), "row_order", {13'd0, row_seen}, {13'd0, row_after(prev_row)});
                n_chg++;
            end
        end
        chk(n_chg >= 20, "row_cycling", 16'(n_chg), 16'd20);
        keys = 9'd0;
        repeat (10) tick();

        // c: short release is absorbed, full release allows a second pulse
        keys = 9'b000000100;
        push_exp(4'd2, 9'b000000100);
        wait_empty(LAT + 40);
        repeat (40) tick();
        keys = 9'd0;
        repeat (5) tick();
        keys = 9'b000000100;
        repeat (30) tick();
        keys = 9'd0;
        repeat (20) tick();
        keys = 9'b000000100;
        push_exp(4'd2, 9'b000000100);
        wait_empty(LAT + 40);
        repeat (10) tick();
        keys = 9'd0;
        repeat (30) tick();

        // scan_en dropped while i is debouncing
        wait_row(2);
        keys = 9'b100000000;
        repeat (8) tick();
        scan_en = 1'b0;
        tick();
        chk(row_n == 3'b111, "scan_off_rows", {13'd0, row_n}, 16'h0007);
        chk(key_code == 4'd2, "scan_off_code", {12'd0, key_code}, 16'h0002);
        repeat (40) tick();
        keys = 9'd0;
        scan_en = 1'b1;
        repeat (20) tick();

        // reset asserted while i is debouncing
        wait_row(2);
        keys = 9'b100000000;
        repeat (8) tick();
        reset = 1'b0;
        #1;
        chk(row_n == 3'b111, "rst_mid_rows", {13'd0, row_n}, 16'h0007);
        chk(key_code == 4'hF, "rst_mid_code", {12'd0, key_code}, 16'h000F);
        chk(btn_vec == 9'd0 && key_valid == 1'b0, "rst_mid_cells", {7'd0, btn_vec}, 16'd0);
        keys = 9'd0;
        repeat (3) tick();
        reset = 1'b1;
        repeat (40) tick();
        chk(key_code == 4'hF, "post_rst_code", {12'd0, key_code}, 16'h000F);

        // h held 170 clocks after its first pulse: repeats only with auto-repeat built in
        keys = 9'b010000000;
        push_exp(4'd7, 9'b010000000);
        wait_empty(LAT + 40);
        n0 = pulses;
        base = pulse_times.size() - 1;
        for (int k = 0; k < EXP_RPT; k++) push_exp(4'd7, 9'b010000000);
        repeat (170) tick();
        keys = 9'd0;
        repeat (40) tick();
        chk(pulses - n0 == EXP_RPT, "repeat_count", 16'(pulses - n0), 16'(EXP_RPT));
        chk(exp_q.size() == 0, "repeat_pending", 16'(exp_q.size()), 16'd0);
        for (int k = 1; k <= EXP_RPT; k++) begin
            if (pulse_times.size() > base + k)
                chk(pulse_times[base+k] - pulse_times[base+k-1] == 50, "repeat_spacing",
                    16'(pulse_times[base+k] - pulse_times[base+k-1]), 16'd50);
            else
                chk(pulse_times.size() > base + k, "repeat_missing", 16'(pulse_times.size()), 16'(base + k + 1));
        end
        exp_q.delete();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16, SHALL set the number of consecutive stable samples required to accept a press or release (range 2..255).
REQ-002 Parameter SETTLE_CYCLES, default 2, SHALL set the number of clocks the driven row settles before columns are sampled (range 1..15).
REQ-003 Parameter REPEAT_CYCLES, default 200, SHALL set the auto-repeat interval (range 2..65535); it is used only under REQ-027.
REQ-004 Port list: clk  input  1  single system clock, all state rising-edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 scan_en  input  1  high enables scanning.
REQ-007 col_n  input  3  keypad column sense, active-low, externally pulled up, asynchronous to clk.
REQ-008 row_n  output  3  keypad row drive, active-low, at most one bit low.
REQ-009 a_button..i_button  output  1 each  one-clock active-high press pulse per cell, feeding the game-board button inputs.
REQ-010 key_valid  output  1  high for the same cycle as any cell pulse.
REQ-011 key_code  output  4  last accepted key, 0..8 for a..i, 4'hF when no key has been accepted since reset.

Function
REQ-012 col_n SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value.
REQ-013 Mapping: row0 cols0..2 = a,b,c; row1 = d,e,f; row2 = g,h,i.
REQ-014 FSM states: IDLE, SETTLE, SAMPLE, DEBOUNCE, PRESS, HOLD, RELEASE.
REQ-015 IDLE: row_n=3'b111; when scan_en=1, go to SETTLE with row 0 driven.
REQ-016 SETTLE: drive current row for SETTLE_CYCLES clocks, then SAMPLE.
REQ-017 SAMPLE: exactly one synchronized column low -> latch (row,col), go to DEBOUNCE; zero or more than one low -> advance row (2 wraps to 0), go to SETTLE.
REQ-018 DEBOUNCE: keep the row; each clock the same single column SHALL be low; after DEBOUNCE_CYCLES consecutive matches go to PRESS; any mismatch -> advance row, go to SETTLE.
REQ-019 PRESS: lasts one clock; assert the mapped cell output and key_valid, update key_code; next state HOLD.
REQ-020 HOLD: stay while the latched column is low; when it reads high go to RELEASE.
REQ-021 RELEASE: require DEBOUNCE_CYCLES consecutive all-high columns on the held row, then advance row and go to SETTLE; any column low restarts the count, and the FSM returns to HOLD if the latched column is low.
REQ-022 At most one cell output SHALL be high in any cycle; no second pulse SHALL occur until the release is debounced (except REQ-027).
REQ-023 Press latency: the pulse SHALL occur exactly 2 (sync) + DEBOUNCE_CYCLES + 1 clocks after the SAMPLE cycle, measured from the stable col_n edge when the row is already driven.
REQ-024 scan_en deasserted in any state SHALL force IDLE on the next clock, suppress any pending pulse, drive row_n=3'b111, and keep key_code unchanged.
REQ-025 Counters SHALL saturate and never wrap; the row index SHALL never take the value 3.

Reset
REQ-026 reset low SHALL asynchronously force: state IDLE, row index 0, row_n=3'b111, all cell outputs and key_valid 0, key_code 4'hF, synchronizer flops 3'b111, counters 0; deassertion mid-press SHALL yield no pulse until a fresh debounced press.

Configuration
REQ-027 Macro KEYPAD_AUTOREPEAT_EN: when defined, in HOLD a further PRESS pulse for the same key SHALL be emitted every REPEAT_CYCLES clocks while the key stays low; when undefined, HOLD emits no pulses and the repeat counter SHALL not exist.

Verification
REQ-028 Reset, scan_en=1, press e (row1,col1) stable for 40 clocks -> one-cycle e_button=1, key_valid=1, key_code=4, no other pulse.
REQ-029 Press g with bounce (toggling every 3 clocks for 30 clocks, then stable) -> exactly one g_button pulse, issued only after stable low held for 16 samples.
REQ-030 Hold a and b together (same row) -> no pulse, rows keep cycling 110,101,011 repeatedly.
REQ-031 Press c, release for 5 clocks, press c again (DEBOUNCE_CYCLES=16) -> only one c_button pulse; after a 20-clock release a second press yields a second pulse.
REQ-032 Drop scan_en or assert reset during DEBOUNCE of key i -> no i_button pulse, row_n=3'b111 next clock (reset: key_code=4'hF).
REQ-033 With KEYPAD_AUTOREPEAT_EN, REPEAT_CYCLES=50, hold h for 170 clocks after its first pulse -> 3 further h_button pulses spaced 50 clocks apart; without the macro -> none.
